// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if
//   Bundles the decode-side hazard inputs and the pipeline-control outputs
//   of hazard_ctrl so that the pipeline and the controller share one port.
//
//   master : the pipeline. It drives the ID/EX decode information and
//            consumes the stall/bubble controls and performance counters.
//   slave  : hazard_ctrl.
//
//   Signals
//     rAID, rBID   source register IDs of the ID instruction
//     rBValid      rBID is really read by the ID instruction
//     rWEX         destination register of the EX instruction
//     memReadEX    EX instruction is a load
//     isJmp, bSucc EX instruction is a jump / taken branch
//     mdStartEX    EX instruction issues a mul/div
//     mdUseID      ID instruction reads HI/LO or is a mul/div
//     stall        hold PC and IF/ID
//     Bubid        load a bubble into ID/EX
//     Bubif        flush IF/ID
//     mdBusy       mul/div result not yet available
//     stallCnt     saturating count of stall cycles
//     flushCnt     saturating count of flush cycles
interface hazard_ctrl_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
);
  logic [REG_AW-1:0] rAID;
  logic [REG_AW-1:0] rBID;
  logic              rBValid;
  logic [REG_AW-1:0] rWEX;
  logic              memReadEX;
  logic              isJmp;
  logic              bSucc;
  logic              mdStartEX;
  logic              mdUseID;
  logic              stall;
  logic              Bubid;
  logic              Bubif;
  logic              mdBusy;
  logic [CNT_W-1:0]  stallCnt;
  logic [CNT_W-1:0]  flushCnt;

  modport master (
    output rAID, rBID, rBValid, rWEX, memReadEX, isJmp, bSucc, mdStartEX, mdUseID,
    input  stall, Bubid, Bubif, mdBusy, stallCnt, flushCnt
  );

  modport slave (
    input  rAID, rBID, rBValid, rWEX, memReadEX, isJmp, bSucc, mdStartEX, mdUseID,
    output stall, Bubid, Bubif, mdBusy, stallCnt, flushCnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl
//   Hazard and bubble controller for the forwarding 5-stage MIPS pipeline.
//   Detects load-use hazards (stalling for LOAD_STALL cycles), tracks a
//   busy window for the multi-cycle mul/div unit, squashes on jumps and
//   taken branches (flush beats stall), and keeps saturating stall/flush
//   event counters.
//
//   Ports
//     clk  pipeline clock, rising edge
//     rst  asynchronous active-high reset
//     bus  hazard_ctrl_if.slave: decode inputs in, stall/bubble controls
//          and counters out (see the interface header for the list)
//
//   Parameters
//     REG_AW      register-ID width
//     LOAD_STALL  stall cycles per load-use hazard (>=1)
//     MD_LAT      mul/div latency after issue from EX (>=1)
//     CNT_W       performance counter width
module hazard_ctrl #(
  parameter int REG_AW     = 5,
  parameter int LOAD_STALL = 1,
  parameter int MD_LAT     = 4,
  parameter int CNT_W      = 16
) (
  input  logic           clk,
  input  logic           rst,
  hazard_ctrl_if.slave   bus
);

  // A one-cycle load stall needs no remaining-cycle counter, but keep at
  // least one bit so the register is always legal.
  localparam int LU_W = (LOAD_STALL > 1) ? $clog2(LOAD_STALL) : 1;
  localparam int MD_W = $clog2(MD_LAT + 1);

  localparam logic [LU_W-1:0]   LU_MAX = LU_W'(LOAD_STALL - 1);
  localparam logic [MD_W-1:0]   MD_MAX = MD_W'(MD_LAT);
  localparam logic [REG_AW-1:0] R_ZERO = '0;

  logic [LU_W-1:0] luCnt_reg, luCnt_next;
  logic [MD_W-1:0] mdCnt_reg, mdCnt_next;

  logic flush;
  logic loadHit;
  logic luActive;
  logic stallLU;
  logic mdBusyInt;
  logic stallMD;
  logic stallInt;

  always_comb begin
    flush   = bus.isJmp | bus.bSucc;
    // Register 0 is hardwired, so a load targeting it never creates a hazard.
    loadHit = bus.memReadEX & (bus.rWEX != R_ZERO) &
              ((bus.rWEX == bus.rAID) | (bus.rBValid & (bus.rWEX == bus.rBID)));

    // luCnt holds the stall cycles still owed after the detection cycle;
    // while it is nonzero a fresh loadHit is part of the same hazard.
    luActive  = (luCnt_reg != '0);
    stallLU   = (loadHit & ~luActive) | luActive;

    mdBusyInt = (mdCnt_reg != '0);
    // The issue cycle itself already blocks a dependent ID instruction.
    stallMD   = bus.mdUseID & (mdBusyInt | bus.mdStartEX);

    // The ID instruction is squashed on a flush, so holding it is pointless.
    stallInt  = (stallLU | stallMD) & ~flush;
  end

  always_comb begin
    luCnt_next = luCnt_reg;
    if (flush) begin
      luCnt_next = '0;
    end else if (luActive) begin
      luCnt_next = luCnt_reg - 1'b1;
    end else if (loadHit) begin
      luCnt_next = LU_MAX;
    end
  end

  // Flush does not touch the mul/div window: the issuing op is older than
  // the branch and keeps executing.
  always_comb begin
    mdCnt_next = mdCnt_reg;
    if (bus.mdStartEX) begin
      mdCnt_next = MD_MAX;
    end else if (mdBusyInt) begin
      mdCnt_next = mdCnt_reg - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      luCnt_reg <= '0;
      mdCnt_reg <= '0;
    end else begin
      luCnt_reg <= luCnt_next;
      mdCnt_reg <= mdCnt_next;
    end
  end

  // Event counters: index 0 counts stall cycles, index 1 flush cycles.
  logic [1:0]       cntEvt;
  logic [CNT_W-1:0] cnt_reg [2];

  assign cntEvt = {flush, stallInt};

  for (genvar gi = 0; gi < 2; gi++) begin : gCnt
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt_reg[gi] <= '0;
      end else if (cntEvt[gi] && (cnt_reg[gi] != {CNT_W{1'b1}})) begin
        cnt_reg[gi] <= cnt_reg[gi] + CNT_W'(1);
      end
    end
  end

  assign bus.stall    = stallInt;
  assign bus.Bubid    = flush | stallInt;
  assign bus.Bubif    = flush;
  assign bus.mdBusy   = mdBusyInt;
  assign bus.stallCnt = cnt_reg[0];
  assign bus.flushCnt = cnt_reg[1];

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl
//   Drives two hazard_ctrl instances with the same decode stimulus:
//     A: LOAD_STALL=1, MD_LAT=4, CNT_W=16
//     B: LOAD_STALL=3, MD_LAT=4, CNT_W=4
//   A window-based reference model predicts every output of both instances
//   each cycle; directed steps add hand-computed literal expectations.
module tb_hazard_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [4:0] rAID = '0, rBID = '0, rWEX = '0;
  logic rBValid = 1'b0, memReadEX = 1'b0, isJmp = 1'b0, bSucc = 1'b0;
  logic mdStartEX = 1'b0, mdUseID = 1'b0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hazard_ctrl_if #(.REG_AW(5), .CNT_W(16)) ifA ();
  hazard_ctrl_if #(.REG_AW(5), .CNT_W(4))  ifB ();

  assign ifA.rAID = rAID;           assign ifB.rAID = rAID;
  assign ifA.rBID = rBID;           assign ifB.rBID = rBID;
  assign ifA.rBValid = rBValid;     assign ifB.rBValid = rBValid;
  assign ifA.rWEX = rWEX;           assign ifB.rWEX = rWEX;
  assign ifA.memReadEX = memReadEX; assign ifB.memReadEX = memReadEX;
  assign ifA.isJmp = isJmp;         assign ifB.isJmp = isJmp;
  assign ifA.bSucc = bSucc;         assign ifB.bSucc = bSucc;
  assign ifA.mdStartEX = mdStartEX; assign ifB.mdStartEX = mdStartEX;
  assign ifA.mdUseID = mdUseID;     assign ifB.mdUseID = mdUseID;

  hazard_ctrl #(.REG_AW(5), .LOAD_STALL(1), .MD_LAT(4), .CNT_W(16)) dutA (
    .clk(clk), .rst(rst), .bus(ifA)
  );
  hazard_ctrl #(.REG_AW(5), .LOAD_STALL(3), .MD_LAT(4), .CNT_W(4)) dutB (
    .clk(clk), .rst(rst), .bus(ifB)
  );

  // Actual outputs gathered per instance for the compare loop.
  logic aStall[2], aBubid[2], aBubif[2], aBusy[2];
  int   aSCnt[2], aFCnt[2];
  assign aStall[0] = ifA.stall;   assign aStall[1] = ifB.stall;
  assign aBubid[0] = ifA.Bubid;   assign aBubid[1] = ifB.Bubid;
  assign aBubif[0] = ifA.Bubif;   assign aBubif[1] = ifB.Bubif;
  assign aBusy[0]  = ifA.mdBusy;  assign aBusy[1]  = ifB.mdBusy;
  assign aSCnt[0]  = int'(ifA.stallCnt); assign aSCnt[1] = int'(ifB.stallCnt);
  assign aFCnt[0]  = int'(ifA.flushCnt); assign aFCnt[1] = int'(ifB.flushCnt);

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic lit(input string nm, input int act, input int exp);
    $display("step %-16s actual=%0d expected=%0d", nm, act, exp);
    chk(nm, act, exp);
  endtask

  // ---------------- reference model ----------------
  // A load-use hazard opens a stall window of LS cycles starting at the
  // detection cycle; a flush closes it. A mul/div issue at cycle t makes the
  // unit busy for cycles t+1..t+MD.
  int mLS[2]   = '{1, 3};
  int mMD[2]   = '{4, 4};
  int mCMax[2] = '{65535, 15};
  bit mLoadV[2];
  int mLoadStart[2];
  bit mMdV[2];
  int mMdIssue[2];
  int mSCnt[2];
  int mFCnt[2];
  int cyc = 0;

  task automatic modelClear();
    for (int i = 0; i < 2; i++) begin
      mLoadV[i] = 1'b0; mMdV[i] = 1'b0; mSCnt[i] = 0; mFCnt[i] = 0;
      mLoadStart[i] = 0; mMdIssue[i] = 0;
    end
  endtask

  initial modelClear();
  always @(posedge rst) modelClear();

  always @(negedge clk) begin
    bit fl, hit, inWin, busy, sLU, sMD, st;
    if (rst) modelClear();
    fl  = isJmp | bSucc;
    hit = memReadEX && (rWEX != 0) &&
          ((rWEX == rAID) || (rBValid && (rWEX == rBID)));
    for (int i = 0; i < 2; i++) begin
      inWin = mLoadV[i] && ((cyc - mLoadStart[i]) < mLS[i]);
      busy  = mMdV[i] && ((cyc - mMdIssue[i]) >= 1) && ((cyc - mMdIssue[i]) <= mMD[i]);
      sLU   = inWin || hit;
      sMD   = mdUseID && (busy || mdStartEX);
      st    = (sLU || sMD) && !fl;
      chk($sformatf("cyc%0d_i%0d_stall", cyc, i), int'(aStall[i]), int'(st));
      chk($sformatf("cyc%0d_i%0d_Bubid", cyc, i), int'(aBubid[i]), int'(st || fl));
      chk($sformatf("cyc%0d_i%0d_Bubif", cyc, i), int'(aBubif[i]), int'(fl));
      chk($sformatf("cyc%0d_i%0d_mdBusy", cyc, i), int'(aBusy[i]), int'(busy));
      chk($sformatf("cyc%0d_i%0d_stallCnt", cyc, i), aSCnt[i], mSCnt[i]);
      chk($sformatf("cyc%0d_i%0d_flushCnt", cyc, i), aFCnt[i], mFCnt[i]);
      if (!rst) begin
        if (fl) mLoadV[i] = 1'b0;
        else if (!inWin && hit) begin
          mLoadV[i] = 1'b1; mLoadStart[i] = cyc;
        end
        if (mdStartEX) begin
          mMdV[i] = 1'b1; mMdIssue[i] = cyc;
        end
        if (st && mSCnt[i] < mCMax[i]) mSCnt[i]++;
        if (fl && mFCnt[i] < mCMax[i]) mFCnt[i]++;
      end
    end
    cyc++;
  end

  // ---------------- directed stimulus ----------------
  task automatic nextCycle(); @(posedge clk); #1; endtask
  task automatic probe();     @(negedge clk); #1; endtask

  task automatic clearIn();
    rAID = 0; rBID = 0; rWEX = 0; rBValid = 0; memReadEX = 0;
    isJmp = 0; bSucc = 0; mdStartEX = 0; mdUseID = 0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    probe();
    lit("rst_stallA", ifA.stall, 0);     lit("rst_stallB", ifB.stall, 0);
    lit("rst_BubidA", ifA.Bubid, 0);     lit("rst_BubifA", ifA.Bubif, 0);
    lit("rst_mdBusyA", ifA.mdBusy, 0);   lit("rst_sCntB", int'(ifB.stallCnt), 0);
    lit("rst_fCntA", int'(ifA.flushCnt), 0);

    // Load-use on rA.
    nextCycle(); rWEX = 5; rAID = 5; memReadEX = 1;
    probe();
    lit("lu1_stallA", ifA.stall, 1); lit("lu1_BubidA", ifA.Bubid, 1);
    lit("lu1_BubifA", ifA.Bubif, 0); lit("lu1_stallB", ifB.stall, 1);
    nextCycle(); clearIn();
    probe(); lit("lu2_stallA", ifA.stall, 0); lit("lu2_stallB", ifB.stall, 1);
    nextCycle(); probe(); lit("lu3_stallB", ifB.stall, 1);
    nextCycle(); probe(); lit("lu4_stallB", ifB.stall, 0);
    lit("lu4_sCntB", int'(ifB.stallCnt), 3); lit("lu4_sCntA", int'(ifA.stallCnt), 1);

    // Load-use on rB, taken branch in the second stall cycle.
    nextCycle(); rBID = 7; rBValid = 1; rWEX = 7; memReadEX = 1;
    probe(); lit("br1_stallB", ifB.stall, 1);
    nextCycle(); clearIn(); bSucc = 1;
    probe(); lit("br2_stallB", ifB.stall, 0); lit("br2_BubidB", ifB.Bubid, 1);
    lit("br2_BubifB", ifB.Bubif, 1);
    nextCycle(); clearIn();
    probe(); lit("br3_stallB", ifB.stall, 0); lit("br3_fCntB", int'(ifB.flushCnt), 1);
    lit("br3_fCntA", int'(ifA.flushCnt), 1); lit("br3_sCntB", int'(ifB.stallCnt), 4);

    // mul/div issue with a dependent ID instruction from the issue cycle.
    nextCycle(); mdStartEX = 1; mdUseID = 1;
    probe(); lit("md0_stallA", ifA.stall, 1); lit("md0_busyA", ifA.mdBusy, 0);
    for (int k = 1; k <= 5; k++) begin
      nextCycle(); mdStartEX = 0;
      probe();
      lit($sformatf("md%0d_stallA", k), ifA.stall, (k <= 4) ? 1 : 0);
      lit($sformatf("md%0d_busyA", k), ifA.mdBusy, (k <= 4) ? 1 : 0);
    end
    lit("md_sCntA", int'(ifA.stallCnt), 7); lit("md_sCntB", int'(ifB.stallCnt), 9);

    // Non-hazards and a jump.
    nextCycle(); clearIn(); memReadEX = 1;
    probe(); lit("r0_stallA", ifA.stall, 0); lit("r0_stallB", ifB.stall, 0);
    nextCycle(); rWEX = 7; rBID = 7; rAID = 3; rBValid = 0;
    probe(); lit("rbinv_stallA", ifA.stall, 0); lit("rbinv_stallB", ifB.stall, 0);
    nextCycle(); clearIn(); isJmp = 1;
    probe(); lit("jmp_BubidA", ifA.Bubid, 1); lit("jmp_BubifA", ifA.Bubif, 1);
    lit("jmp_stallA", ifA.stall, 0);

    // Long stall: B's counter saturates, then async reset mid-stall.
    nextCycle(); clearIn(); rWEX = 9; rAID = 9; memReadEX = 1;
    for (int k = 0; k < 20; k++) begin
      probe(); nextCycle();
    end
    mdStartEX = 1;
    nextCycle(); mdStartEX = 0;
    probe();
    lit("sat_sCntB", int'(ifB.stallCnt), 15); lit("sat_sCntA", int'(ifA.stallCnt), 28);
    lit("sat_busyA", ifA.mdBusy, 1);
    #1 rst = 1'b1;
    #1;
    lit("arst_sCntA", int'(ifA.stallCnt), 0); lit("arst_sCntB", int'(ifB.stallCnt), 0);
    lit("arst_fCntA", int'(ifA.flushCnt), 0); lit("arst_busyB", ifB.mdBusy, 0);
    lit("arst_stallA", ifA.stall, 1);
    nextCycle(); rst = 1'b0; clearIn();
    probe(); lit("post_stallB", ifB.stall, 0); lit("post_busyA", ifA.mdBusy, 0);

    // Mixed vectors over a tiny register space so hazards overlap often.
    for (int k = 0; k < 60; k++) begin
      nextCycle();
      rAID = 5'($urandom_range(0, 3)); rBID = 5'($urandom_range(0, 3));
      rWEX = 5'($urandom_range(0, 3)); rBValid = 1'($urandom_range(0, 1));
      memReadEX = 1'($urandom_range(0, 1)); mdUseID = 1'($urandom_range(0, 1));
      mdStartEX = ($urandom_range(0, 5) == 0);
      isJmp = ($urandom_range(0, 9) == 0); bSucc = ($urandom_range(0, 9) == 0);
    end
    nextCycle(); clearIn();
    probe(); probe();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
